// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - memory-access stage and MEM/WB pipeline register
//
// Purpose:
//   Consumer end of the EX/MEM register. Non-memory instructions pass
//   straight into MEM/WB in one cycle. LW/SW launch a request on a
//   variable-latency req/ack data-memory port and hold the upstream
//   pipeline (stall) until the responder acknowledges or the wait counter
//   expires. MEM/WB carries load data, ALU result, instruction, PC and the
//   decoded write-back controls for the WB stage.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   in_valid              EX/MEM holds a valid instruction
//   alureg_input          ALU result / memory address
//   ir_input, pc_input    instruction and PC
//   store_data_input      SW write data
//   dmem_write_enable     store control from EX/MEM
//   stall                 combinational; upstream holds while high
//   dmem_req, dmem_we     registered request and write strobe
//   dmem_addr, dmem_wdata registered address and store data
//   dmem_ack, dmem_rdata  responder completion and load data
//   wb_valid              MEM/WB holds a valid instruction
//   lmd_output            load data (0 for non-loads)
//   alureg_output         ALU result / address
//   ir_output, pc_output  instruction and PC
//   reg_write_enable      WB writes the register file
//   wb_sel                0 = ALU result, 1 = load data
//   wb_dest               destination register
//   mem_fault             sticky: an access timed out
module mem_wb #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] alureg_input,
  input  logic [31:0] ir_input,
  input  logic [31:0] pc_input,
  input  logic [31:0] store_data_input,
  input  logic        dmem_write_enable,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] lmd_output,
  output logic [31:0] alureg_output,
  output logic [31:0] ir_output,
  output logic [31:0] pc_output,
  output logic        reg_write_enable,
  output logic        wb_sel,
  output logic [4:0]  wb_dest,
  output logic        mem_fault
);

  // Only the opcodes that change behaviour here are named; BNE, J and any
  // unknown opcode all decode to "no write-back".
  localparam logic [5:0] OP_OPERATION = 6'b000000;
  localparam logic [5:0] OP_LW        = 6'b100011;
  localparam logic [5:0] OP_SW        = 6'b101011;

  // The counter only ever holds 0 .. ACK_TIMEOUT-1.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_ir;
  logic [31:0]        r_pc;

  logic               w_stall;
  logic               w_ack_done;
  logic               w_timeout;
  logic               w_in_mem;
  logic               w_cap_lw;
  logic [6:0]         w_in_dec;
  logic [6:0]         w_cap_dec;

  // Returns {write, sel, dest}. A zero destination never writes, so
  // writes to r0 are squashed here rather than in the register file.
  function automatic logic [6:0] decode_wb(input logic [31:0] ir);
    logic       wr;
    logic       sel;
    logic [4:0] dest;
    wr   = 1'b0;
    sel  = 1'b0;
    dest = 5'd0;
    case (ir[31:26])
      OP_OPERATION: begin
        wr   = 1'b1;
        dest = ir[15:11];
      end
      OP_LW: begin
        wr   = 1'b1;
        sel  = 1'b1;
        dest = ir[20:16];
      end
      default: begin
        wr   = 1'b0;
      end
    endcase
    if (dest == 5'd0) begin
      wr = 1'b0;
    end
    return {wr, sel, dest};
  endfunction

  assign w_in_mem  = (ir_input[31:26] == OP_LW) || (ir_input[31:26] == OP_SW);
  assign w_cap_lw  = (r_ir[31:26] == OP_LW);
  assign w_in_dec  = decode_wb(ir_input);
  assign w_cap_dec = decode_wb(r_ir);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stall drops in the completing cycle (ack or timeout) so that upstream
  // advances on the same edge that loads MEM/WB.
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_ack_done   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && w_in_mem) begin
          w_stall      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (dmem_ack) begin
          w_ack_done   = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_stall      = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (reset) begin
      w_state_next = S_IDLE;
      w_stall      = 1'b0;
      w_ack_done   = 1'b0;
      w_timeout    = 1'b0;
    end
  end

  assign stall = w_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt            <= '0;
      r_ir             <= 32'd0;
      r_pc             <= 32'd0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= 32'd0;
      dmem_wdata       <= 32'd0;
      wb_valid         <= 1'b0;
      lmd_output       <= 32'd0;
      alureg_output    <= 32'd0;
      ir_output        <= 32'd0;
      pc_output        <= 32'd0;
      reg_write_enable <= 1'b0;
      wb_sel           <= 1'b0;
      wb_dest          <= 5'd0;
      mem_fault        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!in_valid) begin
            wb_valid         <= 1'b0;
            lmd_output       <= 32'd0;
            alureg_output    <= 32'd0;
            ir_output        <= 32'd0;
            pc_output        <= 32'd0;
            reg_write_enable <= 1'b0;
            wb_sel           <= 1'b0;
            wb_dest          <= 5'd0;
          end else if (w_in_mem) begin
            // Launch the access; MEM/WB keeps its contents but is
            // marked invalid until the access completes.
            dmem_req   <= 1'b1;
            dmem_we    <= dmem_write_enable;
            dmem_addr  <= alureg_input;
            dmem_wdata <= store_data_input;
            r_ir       <= ir_input;
            r_pc       <= pc_input;
            wb_valid   <= 1'b0;
          end else begin
            wb_valid         <= 1'b1;
            lmd_output       <= 32'd0;
            alureg_output    <= alureg_input;
            ir_output        <= ir_input;
            pc_output        <= pc_input;
            reg_write_enable <= w_in_dec[6];
            wb_sel           <= w_in_dec[5];
            wb_dest          <= w_in_dec[4:0];
          end
        end
        S_WAIT: begin
          if (w_ack_done || w_timeout) begin
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            wb_valid         <= 1'b1;
            alureg_output    <= dmem_addr;
            ir_output        <= r_ir;
            pc_output        <= r_pc;
            wb_sel           <= w_cap_dec[5];
            wb_dest          <= w_cap_dec[4:0];
            if (w_ack_done) begin
              lmd_output       <= w_cap_lw ? dmem_rdata : 32'd0;
              reg_write_enable <= w_cap_dec[6];
            end else begin
              // Aborted access: retire the instruction without a write.
              lmd_output       <= 32'd0;
              reg_write_enable <= 1'b0;
              mem_fault        <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
